// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl
//   Control for the IF stage and the IF/ID register. Each cycle it folds the
//   memory stall, the data-hazard stall and a taken branch into one set of
//   PC / freeze / flush controls. A taken branch that arrives while memory is
//   stalled is held and replayed once memory is ready. It also keeps two
//   saturating debug counters: stall cycles and redirects.
// Ports
//   clk_i            clock, all state changes on the rising edge
//   rst_i            synchronous reset, active low
//   mem_ready_i      MEM stage ready; 0 stalls the whole pipe
//   hazard_i         data hazard from the hazard unit (level)
//   branch_taken_i   EXE resolved a taken branch this cycle
//   branch_addr_i    branch target, valid with branch_taken_i
//   pc_ld_o          PC register load enable
//   pc_sel_o         0 = PC+4, 1 = pc_target_o
//   pc_target_o      redirect address, valid when pc_sel_o = 1
//   if_freeze_o      hold the IF/ID register
//   if_flush_o       clear the IF/ID register
//   id_flush_o       clear the ID/EXE register
//   pipe_freeze_o    hold the ID/EXE, EXE/MEM and MEM/WB registers
//   stall_cnt_o      saturating count of non-BOOT cycles with pc_ld_o = 0
//   flush_cnt_o      saturating count of redirects issued
module fetch_pipe_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_ready_i,
  input  logic              hazard_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              pc_ld_o,
  output logic              pc_sel_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic              if_freeze_o,
  output logic              if_flush_o,
  output logic              id_flush_o,
  output logic              pipe_freeze_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, MWAIT = 2'd2} state_e;

  localparam logic [3:0]       BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [3:0]          boot_q, boot_d;
  logic                pend_v_q, pend_v_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    flush_q, flush_d;
  logic                redirect;

  // Outputs are Mealy so a stall or redirect acts in the cycle it is seen.
  // BOOT drives constants only, so X on the inputs cannot reach the outputs.
  always_comb begin
    pc_ld_o       = 1'b1;
    pc_sel_o      = 1'b0;
    pc_target_o   = '0;
    if_freeze_o   = 1'b0;
    if_flush_o    = 1'b0;
    id_flush_o    = 1'b0;
    pipe_freeze_o = 1'b0;
    redirect      = 1'b0;
    state_d       = state_q;
    boot_d        = boot_q;
    pend_v_d      = pend_v_q;
    pend_addr_d   = pend_addr_q;
    case (state_q)
      BOOT: begin
        pc_ld_o    = 1'b0;
        if_flush_o = 1'b1;
        id_flush_o = 1'b1;
        if (boot_q >= BOOT_LAST) state_d = RUN;
        else                     boot_d  = boot_q + 4'd1;
      end
      default: begin
        state_d = RUN;
        if (!mem_ready_i) begin
          pc_ld_o       = 1'b0;
          if_freeze_o   = 1'b1;
          pipe_freeze_o = 1'b1;
          state_d       = MWAIT;
          // Latest branch seen during the stall is the one replayed.
          if (branch_taken_i) begin
            pend_v_d    = 1'b1;
            pend_addr_d = branch_addr_i;
          end
        end else if (branch_taken_i || pend_v_q) begin
          redirect    = 1'b1;
          pc_sel_o    = 1'b1;
          pc_target_o = branch_taken_i ? branch_addr_i : pend_addr_q;
          if_flush_o  = 1'b1;
          id_flush_o  = 1'b1;
          pend_v_d    = 1'b0;
        end else if (hazard_i) begin
          pc_ld_o     = 1'b0;
          if_freeze_o = 1'b1;
          id_flush_o  = 1'b1;
        end
      end
    endcase
  end

  // BOOT cycles hold pc_ld low but are deliberately not counted as stalls.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q != BOOT && !pc_ld_o && !(&stall_q)) stall_d = stall_q + CNT_ONE;
    if (redirect && !(&flush_q))                    flush_d = flush_q + CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= BOOT;
      boot_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Bench for fetch_pipe_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a reference model that applies the control
// rules directly. A second instance with 4-bit counters shares the inputs
// so counter saturation is reachable in a short run.
module tb_fetch_pipe_ctrl;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, mr, hz, bt;
  logic [AW-1:0] ba;

  logic          pc_ld, pc_sel, if_frz, if_fl, id_fl, p_frz;
  logic [AW-1:0] pc_tgt;
  logic [15:0]   stall_cnt, flush_cnt;
  logic          s_pc_ld, s_pc_sel, s_if_frz, s_if_fl, s_id_fl, s_p_frz;
  logic [AW-1:0] s_pc_tgt;
  logic [3:0]    s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  fetch_pipe_ctrl #(.ADDR_W(AW), .BOOT_CYCLES(2), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .mem_ready_i(mr), .hazard_i(hz),
    .branch_taken_i(bt), .branch_addr_i(ba),
    .pc_ld_o(pc_ld), .pc_sel_o(pc_sel), .pc_target_o(pc_tgt),
    .if_freeze_o(if_frz), .if_flush_o(if_fl), .id_flush_o(id_fl),
    .pipe_freeze_o(p_frz), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));

  fetch_pipe_ctrl #(.ADDR_W(AW), .BOOT_CYCLES(2), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .mem_ready_i(mr), .hazard_i(hz),
    .branch_taken_i(bt), .branch_addr_i(ba),
    .pc_ld_o(s_pc_ld), .pc_sel_o(s_pc_sel), .pc_target_o(s_pc_tgt),
    .if_freeze_o(s_if_frz), .if_flush_o(s_if_fl), .id_flush_o(s_id_fl),
    .pipe_freeze_o(s_p_frz), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt));

  // Reference model state
  int          m_boot_left;
  bit          m_pend;
  logic [AW-1:0] m_paddr;
  int          m_stall, m_flush, m_stall_s, m_flush_s;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  // One clock cycle: apply inputs, check outputs mid-cycle, then advance the model.
  // Control vector order: {pc_ld, pc_sel, if_freeze, if_flush, id_flush, pipe_freeze}
  task automatic step(input logic r, input logic m, input logic h,
                      input logic b, input logic [AW-1:0] a);
    logic [5:0]    e_ctl;
    logic [AW-1:0] e_tgt;
    bit            e_stall, e_redir;
    rst = r; mr = m; hz = h; bt = b; ba = a;
    e_tgt = '0; e_stall = 0; e_redir = 0;
    if (m_boot_left > 0)  e_ctl = 6'b000110;
    else if (m !== 1'b1) begin
      e_ctl = 6'b001001; e_stall = 1;
    end else if (b === 1'b1 || m_pend) begin
      e_ctl = 6'b110110; e_redir = 1;
      e_tgt = (b === 1'b1) ? a : m_paddr;
    end else if (h === 1'b1) begin
      e_ctl = 6'b001010; e_stall = 1;
    end else e_ctl = 6'b100000;
    @(negedge clk);
    chk("ctl",     {pc_ld, pc_sel, if_frz, if_fl, id_fl, p_frz}, e_ctl);
    chk("target",  pc_tgt, e_tgt);
    chk("stall",   stall_cnt, m_stall);
    chk("flush",   flush_cnt, m_flush);
    chk("ctl_s",   {s_pc_ld, s_pc_sel, s_if_frz, s_if_fl, s_id_fl, s_p_frz}, e_ctl);
    chk("stall_s", s_stall_cnt, m_stall_s);
    chk("flush_s", s_flush_cnt, m_flush_s);
    @(posedge clk); #1;
    if (r == 1'b0) begin
      m_boot_left = 2; m_pend = 0; m_paddr = '0;
      m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else if (m_boot_left > 0) m_boot_left--;
    else begin
      if (m !== 1'b1 && b === 1'b1) begin m_pend = 1; m_paddr = a; end
      if (e_redir) begin
        m_pend = 0;
        m_flush = sat(m_flush, 65535); m_flush_s = sat(m_flush_s, 15);
      end
      if (e_stall) begin
        m_stall = sat(m_stall, 65535); m_stall_s = sat(m_stall_s, 15);
      end
    end
  endtask

  // Reset cycles are not checked on the way in (state is unknown before the first edge).
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0; mr = 1'b1; hz = 1'b0; bt = 1'b0; ba = '0;
      @(posedge clk); #1;
    end
    m_boot_left = 2; m_pend = 0; m_paddr = '0;
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
  endtask

  initial begin
    rst = 1'b0; mr = 1'b1; hz = 1'b0; bt = 1'b0; ba = '0;
    // T1: reset, boot with X inputs, then first RUN cycle loads the PC
    do_reset(3);
    step(1, 'x, 'x, 'x, 'x);
    step(1, 'x, 'x, 'x, 'x);
    step(1, 1, 0, 0, 32'h0);
    // T2: hazard two cycles
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    // T3: branch wins over hazard
    step(1, 1, 1, 1, 32'h0000_0040);
    step(1, 1, 0, 0, 32'h0);
    // T4: branch during memory stall, replayed when ready
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 1, 1, 32'h0000_0100);
    step(1, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    // Later branch in a stall overwrites the pending one; live branch beats pending
    step(1, 0, 0, 1, 32'h0000_0200);
    step(1, 0, 0, 1, 32'h0000_0300);
    step(1, 1, 0, 1, 32'h0000_0400);
    step(1, 1, 0, 0, 32'h0);
    // T6: reset while a branch is pending
    step(1, 0, 0, 1, 32'h0000_0500);
    step(0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    // T5: hazard held 20 cycles, 4-bit counter stops at 15
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           AW'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
